inst_queue_param: RTL and testbench

Parametrised circular instruction queue between decoder and ROB/dispatch. It succeeds the fixed 16-entry queue and adds:
- configurable depth and field widths;
- valid/ready enqueue handshake;
- show-ahead head output with stall;
- flush, occupancy count and almost-full flag.
Entries leave in program order when the ROB is not full.

---
 rtl/inst_queue_param.sv | 147 ++++++++++++++
 tb/tb_inst_queue_param.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue_param.sv
// ---------------------------------------------------------------------------
// inst_queue_param
// Circular instruction queue that sits between the decoder and the ROB/dispatch.
// Entries leave in program order. The head entry is shown ahead on out_*.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   flush             discards every stored entry (branch mispredict)
//   in_valid/in_ready decoder enqueue handshake; in_ready = !full
//   in_op..in_has_imm instruction fields to enqueue (NOP_OP is never stored)
//   rob_full          ROB back-pressure; stalls dequeue
//   out_valid..       head entry, combinational from storage; out_op = NOP_OP
//                     when the queue is empty
//   issued            registered pulse: a dequeue happened on the previous edge
//   count             occupancy, 0..DEPTH
//   full/empty/almost_full  status flags decoded from count
// ---------------------------------------------------------------------------
module inst_queue_param #(
  parameter int unsigned          DEPTH    = 16,
  parameter int unsigned          OP_W     = 5,
  parameter int unsigned          REG_W    = 5,
  parameter int unsigned          IMM_W    = 32,
  parameter logic [OP_W-1:0]      NOP_OP   = '1,
  parameter int unsigned          AF_LEVEL = DEPTH - 2,
  localparam int unsigned         PTR_W    = $clog2(DEPTH),
  localparam int unsigned         CNT_W    = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [REG_W-1:0]  in_rs1,
  input  logic [REG_W-1:0]  in_rs2,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic              in_has_imm,
  input  logic              rob_full,
  output logic              out_valid,
  output logic [OP_W-1:0]   out_op,
  output logic [REG_W-1:0]  out_rs1,
  output logic [REG_W-1:0]  out_rs2,
  output logic [REG_W-1:0]  out_rd,
  output logic [IMM_W-1:0]  out_imm,
  output logic              out_has_imm,
  output logic              issued,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              almost_full
);

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic [IMM_W-1:0] imm;
    logic             has_imm;
  } entry_t;

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);

  entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              issued_q, issued_d;

  logic   enq_fire;
  logic   deq_fire;
  entry_t head_entry;
  entry_t in_entry;

  // Status flags come straight from the count register, so in_ready has no
  // combinational dependency on rob_full or on a same-cycle dequeue.
  assign full        = (count_q == DEPTH_CNT);
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= AF_CNT);
  assign count       = count_q;
  assign in_ready    = !full;
  assign issued      = issued_q;

  // A NOP offer completes the handshake but is silently dropped.
  assign enq_fire = in_valid & in_ready & (in_op != NOP_OP);
  assign deq_fire = out_valid & !rob_full;

  assign in_entry = '{op: in_op, rs1: in_rs1, rs2: in_rs2, rd: in_rd,
                      imm: in_imm, has_imm: in_has_imm};

  // Show-ahead head: read asynchronously so the entry is visible the cycle
  // after it is written, with no bypass from in_* to out_*.
  assign head_entry  = mem_q[head_q];
  assign out_valid   = !empty;
  assign out_op      = empty ? NOP_OP : head_entry.op;
  assign out_rs1     = head_entry.rs1;
  assign out_rs2     = head_entry.rs2;
  assign out_rd      = head_entry.rd;
  assign out_imm     = head_entry.imm;
  assign out_has_imm = head_entry.has_imm;

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    issued_d = 1'b0;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      issued_d = deq_fire;
      if (enq_fire) tail_d = tail_q + 1'b1;
      if (deq_fire) head_d = head_q + 1'b1;
      case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      issued_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      issued_q <= issued_d;
    end
  end

  // Storage has no reset; stale contents are unreachable once the pointers
  // and count are cleared.
  always_ff @(posedge clk) begin
    if (rst && !flush && enq_fire) begin
      mem_q[tail_q] <= in_entry;
    end
  end

endmodule

// File: tb/tb_inst_queue_param.sv
module tb_inst_queue_param;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_op;
  logic [4:0]       in_rs1, in_rs2, in_rd;
  logic [31:0]      in_imm;
  logic             in_has_imm;
  logic             rob_full;
  logic             out_valid;
  logic [4:0]       out_op;
  logic [4:0]       out_rs1, out_rs2, out_rd;
  logic [31:0]      out_imm;
  logic             out_has_imm;
  logic             issued;
  logic [CNT_W-1:0] count;
  logic             full, empty, almost_full;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  inst_queue_param #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_imm(in_imm), .in_has_imm(in_has_imm),
    .rob_full(rob_full),
    .out_valid(out_valid), .out_op(out_op),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_has_imm(out_has_imm),
    .issued(issued), .count(count),
    .full(full), .empty(empty), .almost_full(almost_full)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Field pattern derived from the opcode so every field is distinguishable.
  task automatic offer(input logic [4:0] op);
    in_valid   = 1'b1;
    in_op      = op;
    in_rs1     = op ^ 5'h01;
    in_rs2     = op ^ 5'h02;
    in_rd      = op ^ 5'h04;
    in_imm     = 32'hA000_0000 + 32'(op);
    in_has_imm = op[0];
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_op    = 5'd0;
  endtask

  // One edge; outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    $display("cycle %0d: rst=%0b flush=%0b in_valid=%0b in_op=%0d rob_full=%0b -> count=%0d out_valid=%0b out_op=%0d issued=%0b",
             cyc, rst, flush, in_valid, in_op, rob_full, count, out_valid, out_op, issued);
  endtask

  task automatic chk_head(input string tag, input logic [4:0] op);
    chk({tag, ".op"},  32'(out_op), 32'(op));
    chk({tag, ".rs1"}, 32'(out_rs1), 32'(op ^ 5'h01));
    chk({tag, ".rd"},  32'(out_rd), 32'(op ^ 5'h04));
    chk({tag, ".imm"}, out_imm, 32'hA000_0000 + 32'(op));
    chk({tag, ".has_imm"}, 32'(out_has_imm), 32'(op[0]));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".out_valid"},   32'(out_valid), 32'd0);
    chk({tag, ".out_op"},      32'(out_op), 32'h1F);
    chk({tag, ".count"},       32'(count), 32'd0);
    chk({tag, ".empty"},       32'(empty), 32'd1);
    chk({tag, ".full"},        32'(full), 32'd0);
    chk({tag, ".almost_full"}, 32'(almost_full), 32'd0);
    chk({tag, ".in_ready"},    32'(in_ready), 32'd1);
    chk({tag, ".issued"},      32'(issued), 32'd0);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; rob_full = 1'b0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_imm = '0; in_has_imm = 1'b0;
    idle_in();
    #1;

    // 1. reset then idle
    tick(); tick();
    chk_reset_state("reset");
    rst = 1'b1;
    tick();
    chk_reset_state("idle");

    // 2. fill with dequeue stalled
    rob_full = 1'b1;
    offer(5'd1); tick();
    chk("fill1.count", 32'(count), 32'd1);
    chk("fill1.af", 32'(almost_full), 32'd0);
    chk_head("fill1.head", 5'd1);
    offer(5'd2); tick();
    chk("fill2.count", 32'(count), 32'd2);
    chk("fill2.af", 32'(almost_full), 32'd1);
    offer(5'd3); tick();
    offer(5'd4); tick();
    chk("fill4.count", 32'(count), 32'd4);
    chk("fill4.full", 32'(full), 32'd1);
    chk("fill4.in_ready", 32'(in_ready), 32'd0);
    chk("fill4.issued", 32'(issued), 32'd0);
    offer(5'd5); tick();
    chk("over.count", 32'(count), 32'd4);
    chk_head("stall.head", 5'd1);

    // drain; the first drain edge still offers op 5 while full: rejected
    rob_full = 1'b0;
    tick();
    idle_in();
    chk("drain1.count", 32'(count), 32'd3);
    chk("drain1.issued", 32'(issued), 32'd1);
    chk_head("drain1.head", 5'd2);
    tick();
    chk("drain2.issued", 32'(issued), 32'd1);
    chk_head("drain2.head", 5'd3);
    tick();
    chk_head("drain3.head", 5'd4);
    chk("drain3.count", 32'(count), 32'd1);
    tick();
    chk("drain4.empty", 32'(empty), 32'd1);
    chk("drain4.out_op", 32'(out_op), 32'h1F);
    chk("drain4.issued", 32'(issued), 32'd1);
    tick();
    chk("drain5.issued", 32'(issued), 32'd0);

    // 3. simultaneous enqueue/dequeue at count 2
    rob_full = 1'b1;
    offer(5'd5); tick();
    offer(5'd6); tick();
    rob_full = 1'b0;
    offer(5'd7); tick();
    chk("simul.count", 32'(count), 32'd2);
    chk_head("simul.head", 5'd6);
    idle_in(); tick();
    chk_head("simul2.head", 5'd7);
    tick();
    chk("simul.empty", 32'(empty), 32'd1);

    // wrap-around: stream 12 ops through a two-deep backlog
    rob_full = 1'b1;
    offer(5'd8); tick();
    offer(5'd9); tick();
    rob_full = 1'b0;
    for (int k = 10; k < 22; k++) begin
      offer(5'(k)); tick();
      chk("wrap.op", 32'(out_op), 32'(k - 1));
      chk("wrap.count", 32'(count), 32'd2);
    end
    idle_in(); tick();
    chk_head("wrap.tail", 5'd21);
    tick();
    chk("wrap.empty", 32'(empty), 32'd1);

    // 4. NOP filtering
    offer(5'h1F);
    chk("nop.in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("nop.count", 32'(count), 32'd0);
    chk("nop.out_valid", 32'(out_valid), 32'd0);
    idle_in(); tick();
    chk("nop.issued", 32'(issued), 32'd0);

    // 5. flush mid-stream with a live enqueue and dequeue
    rob_full = 1'b1;
    offer(5'd1); tick();
    offer(5'd2); tick();
    offer(5'd3); tick();
    chk("preflush.count", 32'(count), 32'd3);
    rob_full = 1'b0;
    flush = 1'b1;
    offer(5'd4); tick();
    flush = 1'b0;
    chk("flush.count", 32'(count), 32'd0);
    chk("flush.out_valid", 32'(out_valid), 32'd0);
    chk("flush.out_op", 32'(out_op), 32'h1F);
    chk("flush.issued", 32'(issued), 32'd0);
    offer(5'd9); tick();
    idle_in();
    chk("postflush.count", 32'(count), 32'd1);
    chk_head("postflush.head", 5'd9);
    tick();
    chk("postflush.issued", 32'(issued), 32'd1);
    chk("postflush.empty", 32'(empty), 32'd1);

    // 6. mid-stream reset at count 3
    rob_full = 1'b1;
    offer(5'd1); tick();
    offer(5'd2); tick();
    offer(5'd3); tick();
    chk("prerst.af", 32'(almost_full), 32'd1);
    rst = 1'b0;
    offer(5'd5); tick();
    idle_in();
    rob_full = 1'b0;
    chk_reset_state("midrst");
    rst = 1'b1;
    offer(5'd12); tick();
    idle_in();
    chk_head("afterrst.head", 5'd12);
    chk("afterrst.count", 32'(count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
